// File: rtl/regarb_pkg.sv
// Shared types and helpers for the register-file access arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regarb_pkg;

    // Upper bound on the number of requesters the arbiter is built for.
    localparam int REGARB_MAX_REQ = 8;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } regarb_state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int REGARB_AW(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_access_arbiter_rr_arbiter.sv
// Round-robin pick among requesters, searching from last winner + 1.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is accepted.
module rr_arbiter
    import regarb_pkg::*;
#(
    parameter int P_ReqCount = 2,
    parameter int IW         = REGARB_AW(P_ReqCount)
) (
    input  logic [P_ReqCount-1:0] req,
    input  logic [IW-1:0]         last_ptr,
    output logic [P_ReqCount-1:0] grant_onehot,
    output logic [IW-1:0]         grant_idx,
    output logic                  any_req
);

    logic          found;
    logic [IW-1:0] cand;

    assign any_req = |req;

    // Walk the requesters starting just after the last winner; first hit wins.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = '0;
        for (int off = 1; off <= P_ReqCount; off++) begin
            cand = IW'((int'(last_ptr) + off) % P_ReqCount);
            if (!found && req[cand]) begin
                found              = 1'b1;
                grant_idx          = cand;
                grant_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Round-robin sharing of one register file among several requesters (REGARB_WRITE_PROTECT0_EN rejects writes to address 0).
// Latency: grant 1 cycle after request seen idle; done at +2 (write/error) or +3 (read).
// Backpressure: one transaction in flight; requesters hold fields until their grant pulse.
module regfile_access_arbiter
    import regarb_pkg::*;
#(
    parameter int  P_ReqCount = 2,
    parameter int  P_RegCount = 4,
    parameter int  P_BitWidth = 32,
    localparam int AW         = REGARB_AW(P_RegCount),
    localparam int IW         = REGARB_AW(P_ReqCount)
) (
    input  logic                             In_Clock_50MHz,
    input  logic                             In_Reset,
    input  logic [P_ReqCount-1:0]            In_Req,
    input  logic [P_ReqCount-1:0]            In_Write,
    input  logic [P_ReqCount*AW-1:0]         In_Address,
    input  logic [P_ReqCount*P_BitWidth-1:0] In_WriteData,
    output logic [P_ReqCount-1:0]            Out_Grant,
    output logic [P_ReqCount-1:0]            Out_Done,
    output logic [P_BitWidth-1:0]            Out_ReadData,
    output logic                             Out_Error,
    output logic [AW-1:0]                    Out_RF_Address,
    output logic [P_BitWidth-1:0]            Out_RF_WriteData,
    output logic                             Out_RF_Write,
    output logic                             Out_RF_Read,
    input  logic [P_BitWidth-1:0]            In_RF_ReadData
);

    regarb_state_t           state;
    logic [IW-1:0]           ptr;
    logic [P_ReqCount-1:0]   win_onehot;
    logic                    lat_write;
    logic                    lat_reject;

    logic [P_ReqCount-1:0]   arb_onehot;
    logic [IW-1:0]           arb_idx;
    logic                    arb_any;

    logic                    sel_write;
    logic [AW-1:0]           sel_addr;
    logic [P_BitWidth-1:0]   sel_wdata;
    logic                    sel_reject;

    rr_arbiter #(
        .P_ReqCount (P_ReqCount),
        .IW         (IW)
    ) u_rr_arbiter (
        .req          (In_Req),
        .last_ptr     (ptr),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx),
        .any_req      (arb_any)
    );

    // Select the winner's fields and decide up front whether it will be rejected.
    always_comb begin
        sel_write  = In_Write[arb_idx];
        sel_addr   = In_Address[int'(arb_idx)*AW +: AW];
        sel_wdata  = In_WriteData[int'(arb_idx)*P_BitWidth +: P_BitWidth];
        sel_reject = (int'(sel_addr) >= P_RegCount);
`ifdef REGARB_WRITE_PROTECT0_EN
        if (sel_write && (sel_addr == '0)) begin
            sel_reject = 1'b1;
        end
`endif
    end

    // Sequencer: arbitrate, issue one strobe, optionally wait for read data, report done.
    always_ff @(posedge In_Clock_50MHz or posedge In_Reset) begin
        if (In_Reset) begin
            state            <= ST_IDLE;
            ptr              <= IW'(P_ReqCount - 1);
            win_onehot       <= '0;
            lat_write        <= 1'b0;
            lat_reject       <= 1'b0;
            Out_Grant        <= '0;
            Out_Done         <= '0;
            Out_ReadData     <= '0;
            Out_Error        <= 1'b0;
            Out_RF_Address   <= '0;
            Out_RF_WriteData <= '0;
            Out_RF_Write     <= 1'b0;
            Out_RF_Read      <= 1'b0;
        end else begin
            // Pulse outputs fall back to zero unless a state below raises them.
            Out_Grant    <= '0;
            Out_Done     <= '0;
            Out_Error    <= 1'b0;
            Out_RF_Write <= 1'b0;
            Out_RF_Read  <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arb_any) begin
                        ptr        <= arb_idx;
                        win_onehot <= arb_onehot;
                        lat_write  <= sel_write;
                        lat_reject <= sel_reject;
                        Out_Grant  <= arb_onehot;
                        // RF address/data only move when a strobe goes with them.
                        if (!sel_reject) begin
                            Out_RF_Address   <= sel_addr;
                            Out_RF_WriteData <= sel_wdata;
                            Out_RF_Write     <= sel_write;
                            Out_RF_Read      <= !sel_write;
                        end
                        state <= ST_ISSUE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (lat_write || lat_reject) begin
                        Out_Done     <= win_onehot;
                        Out_Error    <= lat_reject;
                        Out_ReadData <= '0;
                        state        <= ST_DONE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    Out_ReadData <= In_RF_ReadData;
                    Out_Done     <= win_onehot;
                    state        <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
